mat_cache_seq: RTL and testbench

MAT_CACHE_SEQ -- requirements
Module: mat_cache_seq

---
 rtl/mat_cache_seq_pkg.sv | 21 ++
 rtl/mat_cache_seq.sv | 162 ++++++++++++++++
 tb/tb_mat_cache_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_cache_seq_pkg.sv
// Shared matrix package: cache port opcodes and the sequencer FSM state type.
package mat_cache_seq_pkg;

  typedef enum logic [1:0] {
    MAT_DATA_WRITE_DISABLE = 2'd0,
    MAT_DATA_WRITE_ROW     = 2'd1,
    MAT_DATA_WRITE_COL     = 2'd2
  } MatDataWriteOp_t;

  typedef enum logic {
    MAT_DATA_READ_ROW = 1'b0,
    MAT_DATA_READ_COL = 1'b1
  } MatDataReadOp_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_LOAD  = 2'd1,
    SEQ_STORE = 2'd2
  } MatCacheSeqState_t;

endpackage

// File: rtl/mat_cache_seq.sv
// Matrix cache sequencer: turns one load/store command into WIDTH row or
// column beats on the matrix cache write/read port.
// Optional stall-cycle counter enabled by macro MAT_CACHE_SEQ_STALL_CNT_EN;
// without it stall_count is tied to zero and no counter register exists.
//
// state     | meaning
// ----------+--------------------------------------------------
// SEQ_IDLE  | waiting for a command, cmd_ready high
// SEQ_LOAD  | writing stream beats into the latched slot
// SEQ_STORE | reading the latched slot out to the stream
module mat_cache_seq
  import mat_cache_seq_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int CACHE_SIZE = 4,
  localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  localparam int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_store,
  input  logic                       cmd_col,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output MatDataWriteOp_t            write_op,
  output logic [CACHE_ADDR_SIZE-1:0] write_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] write_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0] write_param1,
  output logic [WIDTH_ADDR_SIZE-1:0] write_param2,
  output MatDataReadOp_t             read_op,
  output logic [CACHE_ADDR_SIZE-1:0] read_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] read_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0] read_param,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                stall_count
);

  MatCacheSeqState_t          state_q, state_d;
  logic [WIDTH_ADDR_SIZE-1:0] idx_q, idx_d;
  logic [CACHE_ADDR_SIZE-1:0] addr_q, addr_d;
  logic                       col_q, col_d;
  logic                       done_q, done_d;
  logic                       last_idx;

  assign last_idx = (idx_q == WIDTH_ADDR_SIZE'(WIDTH - 1));

  // State, beat index, latched command and done pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      col_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and cache port decode; every output defaults to its idle value
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    col_d        = col_q;
    done_d       = 1'b0;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    write_op     = MAT_DATA_WRITE_DISABLE;
    write_addr1  = '0;
    write_addr2  = '0;
    write_param1 = '0;
    write_param2 = '0;
    read_op      = MAT_DATA_READ_ROW;
    read_addr1   = '0;
    read_addr2   = '0;
    read_param   = '0;
    unique case (state_q)
      SEQ_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          col_d   = cmd_col;
          addr_d  = cmd_addr;
          idx_d   = '0;
          state_d = cmd_store ? SEQ_STORE : SEQ_LOAD;
        end
      end
      SEQ_LOAD: begin
        in_ready     = 1'b1;
        write_addr1  = addr_q;
        write_addr2  = addr_q;
        write_param1 = idx_q;
        if (in_valid) begin
          write_op = col_q ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
          if (last_idx) begin
            idx_d   = '0;
            state_d = SEQ_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + WIDTH_ADDR_SIZE'(1);
          end
        end
      end
      SEQ_STORE: begin
        out_valid  = 1'b1;
        read_op    = col_q ? MAT_DATA_READ_COL : MAT_DATA_READ_ROW;
        read_addr1 = addr_q;
        read_addr2 = addr_q;
        read_param = idx_q;
        if (out_ready) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = SEQ_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + WIDTH_ADDR_SIZE'(1);
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign busy = (state_q != SEQ_IDLE);
  assign done = done_q;

`ifdef MAT_CACHE_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == SEQ_LOAD) && !in_valid) ||
                     ((state_q == SEQ_STORE) && !out_ready);

  // Saturating next value of the stall counter
  always_comb begin
    stall_d = stall_q;
    if (stall_cyc && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mat_cache_seq.sv
// Self-checking bench for mat_cache_seq (WIDTH=4, CACHE_SIZE=4): directed
// scenarios followed by randomized commands against a beat-counting model.
module tb_mat_cache_seq;
  import mat_cache_seq_pkg::*;

  localparam int W  = 4;
  localparam int CS = 4;

  logic clock = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_store, cmd_col;
  logic [1:0] cmd_addr;
  logic in_valid, in_ready, out_valid, out_ready;
  MatDataWriteOp_t write_op;
  MatDataReadOp_t  read_op;
  logic [1:0] write_addr1, write_addr2, write_param1, write_param2;
  logic [1:0] read_addr1, read_addr2, read_param;
  logic busy, done;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mat_cache_seq #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_col(cmd_col), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .write_op(write_op), .write_addr1(write_addr1), .write_addr2(write_addr2),
    .write_param1(write_param1), .write_param2(write_param2),
    .read_op(read_op), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_param(read_param),
    .busy(busy), .done(done), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] exp_stall(input int n);
`ifdef MAT_CACHE_SEQ_STALL_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [1:0] wop(input logic col);
    return col ? MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, writes, nstall, store_cycles, last_p;
    logic r_store, r_col, fire;
    logic [1:0] r_addr;
    logic [6:0] ivpat;

    reset = 1'b1; cmd_valid = 0; cmd_store = 0; cmd_col = 0; cmd_addr = 0;
    in_valid = 0; out_ready = 0;
    tick(); tick();
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_write_op", write_op, MAT_DATA_WRITE_DISABLE);
    chk("rst_read_op", read_op, MAT_DATA_READ_ROW);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall", stall_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // Load row into slot 2 with in_valid held high
    cmd_valid = 1; cmd_store = 0; cmd_col = 0; cmd_addr = 2; in_valid = 1;
    @(negedge clock);
    chk("ld_cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clock);
      chk("ld_write_op", write_op, MAT_DATA_WRITE_ROW);
      chk("ld_waddr1", write_addr1, 2);
      chk("ld_waddr2", write_addr2, 2);
      chk("ld_wparam1", write_param1, i);
      chk("ld_wparam2", write_param2, 0);
      chk("ld_busy", busy, 1);
      chk("ld_done_low", done, 0);
      tick();
    end
    in_valid = 0;
    @(negedge clock);
    chk("ld_done", done, 1);
    chk("ld_busy_fall", busy, 0);
    tick();
    @(negedge clock);
    chk("ld_done_one_cycle", done, 0);

    // Store column from slot 1, out_ready toggling from the accept cycle
    cmd_valid = 1; cmd_store = 1; cmd_col = 1; cmd_addr = 1; out_ready = 1;
    tick();
    cmd_valid = 0;
    k = 0; store_cycles = 0; nstall = 0;
    while (busy && store_cycles < 40) begin
      out_ready = ~out_ready;
      @(negedge clock);
      chk("st_read_op", read_op, MAT_DATA_READ_COL);
      chk("st_raddr1", read_addr1, 1);
      chk("st_raddr2", read_addr2, 1);
      chk("st_rparam", read_param, k);
      chk("st_out_valid", out_valid, 1);
      chk("st_write_op", write_op, MAT_DATA_WRITE_DISABLE);
      if (out_ready) k++; else nstall++;
      store_cycles++;
      tick();
    end
    out_ready = 0;
    @(negedge clock);
    chk("st_cycles", store_cycles, 8);
    chk("st_beats", k, W);
    chk("st_done", done, 1);
    chk("st_stall", stall_count, exp_stall(4));
    tick();

    // Load with a 3-cycle in_valid gap while a second command waits on cmd_valid
    cmd_valid = 1; cmd_store = 0; cmd_col = 1; cmd_addr = 3;
    tick();
    cmd_store = 1; cmd_col = 0; cmd_addr = 3;
    ivpat = 7'b1110001;
    writes = 0; last_p = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = ivpat[c];
      @(negedge clock);
      chk("gap_cmd_ready", cmd_ready, 0);
      chk("gap_write_op", write_op, in_valid ? wop(1'b1) : MAT_DATA_WRITE_DISABLE);
      chk("gap_wparam1", write_param1, writes);
      if (write_op != MAT_DATA_WRITE_DISABLE) writes++;
      tick();
    end
    in_valid = 0;
    chk("gap_writes", writes, W);
    @(negedge clock);
    chk("gap_done", done, 1);
    chk("gap_cmd_ready_done", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    @(negedge clock);
    chk("gap_second_busy", busy, 1);
    chk("gap_second_store", out_valid, 1);
    chk("gap_second_addr", read_addr1, 3);
    chk("gap_second_rop", read_op, MAT_DATA_READ_ROW);
    out_ready = 1;
    tick(); tick(); tick(); tick();
    out_ready = 0;
    @(negedge clock);
    chk("gap_second_done", done, 1);
    tick();

    // Reset after two load beats
    cmd_valid = 1; cmd_store = 0; cmd_col = 0; cmd_addr = 0; in_valid = 1;
    tick();
    cmd_valid = 0;
    tick(); tick();
    reset = 1;
    @(negedge clock);
    chk("rstmid_write_op", write_op, MAT_DATA_WRITE_DISABLE);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    tick();
    reset = 0;
    @(negedge clock);
    chk("rstmid_no_done", done, 0);
    chk("rstmid_stall", stall_count, 0);
    cmd_valid = 1; cmd_store = 0; cmd_col = 0; cmd_addr = 0;
    tick();
    cmd_valid = 0;
    @(negedge clock);
    chk("rstmid_idx0", write_param1, 0);
    for (int i = 1; i < W; i++) tick();
    tick();
    in_valid = 0;
    @(negedge clock);
    chk("rstmid_reload_done", done, 1);
    tick();

    // Randomized commands checked against a beat-counting model
    nstall = 0;
    for (int n = 0; n < 30; n++) begin
      r_store = 1'($urandom_range(0, 1));
      r_col   = 1'($urandom_range(0, 1));
      r_addr  = 2'($urandom_range(0, 3));
      cmd_valid = 1; cmd_store = r_store; cmd_col = r_col; cmd_addr = r_addr;
      @(negedge clock);
      chk("rnd_accept_ready", cmd_ready, 1);
      tick();
      k = 0; cyc = 0;
      while (k < W && cyc < 100) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_store = 1'($urandom_range(0, 1));
        cmd_col   = 1'($urandom_range(0, 1));
        cmd_addr  = 2'($urandom_range(0, 3));
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        chk("rnd_busy", busy, 1);
        chk("rnd_cmd_ready", cmd_ready, 0);
        if (r_store) begin
          chk("rnd_rop", read_op, r_col ? MAT_DATA_READ_COL : MAT_DATA_READ_ROW);
          chk("rnd_raddr", read_addr1, r_addr);
          chk("rnd_rparam", read_param, k);
          chk("rnd_wop_idle", write_op, MAT_DATA_WRITE_DISABLE);
          fire = out_ready;
        end else begin
          chk("rnd_wop", write_op, in_valid ? wop(r_col) : MAT_DATA_WRITE_DISABLE);
          chk("rnd_waddr", write_addr2, r_addr);
          chk("rnd_wparam", write_param1, k);
          chk("rnd_out_valid", out_valid, 0);
          fire = in_valid;
        end
        if (fire) k++; else nstall++;
        cyc++;
        tick();
      end
      cmd_valid = 0; in_valid = 0; out_ready = 0;
      if (cyc >= 100) chk("rnd_timeout", cyc, 0);
      @(negedge clock);
      chk("rnd_done", done, 1);
      chk("rnd_idle", busy, 0);
      chk("rnd_stall", stall_count, exp_stall(nstall));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
